// File: rtl/inst_prefetch_queue.sv
// Byte-wide instruction prefetch queue: loads the reset vector, then streams
// opcode bytes from the fetch address into a circular queue for the decoder.
module inst_prefetch_queue #(
  parameter int unsigned       DEPTH   = 16,
  parameter int unsigned       ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(16'hFFFC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              inst_valid,
  output logic [7:0]        inst_op,
  output logic [7:0]        inst_op1,
  output logic [7:0]        inst_op2,
  output logic [1:0]        avail,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              consume,
  input  logic [1:0]        consume_len,
  output logic              consume_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_VEC_LO = 2'd0,
    ST_VEC_HI = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        vec_lo_q, vec_lo_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              consume_err_q, consume_err_d;
  logic [7:0]        queue_q [DEPTH];

  logic              push_c;
  logic              consume_ok_c;

  // Bus request: vector fetches first, then fill while there is room.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = fetch_addr_q;
    case (state_q)
      ST_VEC_LO: begin
        mem_req  = 1'b1;
        mem_addr = RST_VEC;
      end
      ST_VEC_HI: begin
        mem_req  = 1'b1;
        mem_addr = RST_VEC + ADDR_W'(1);
      end
      default: mem_req = (count_q < CNT_W'(DEPTH));
    endcase
    if (flush || !rst_n) begin
      mem_req = 1'b0;
    end
  end

  // Decoder-facing view of the queue head.
  always_comb begin
    inst_valid  = (count_q != '0);
    avail       = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
    inst_op     = queue_q[head_q];
    inst_op1    = queue_q[head_q + PTR_W'(1)];
    inst_op2    = queue_q[head_q + PTR_W'(2)];
    inst_pc     = inst_pc_q;
    consume_err = consume_err_q;
  end

  assign push_c       = mem_req && mem_ack && (state_q == ST_RUN);
  assign consume_ok_c = consume && !flush && (consume_len != 2'd0) && (consume_len <= avail);

  // Next-state: flush overrides everything, else vector load / push / retire.
  always_comb begin
    state_d       = state_q;
    vec_lo_d      = vec_lo_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_addr_d  = fetch_addr_q;
    inst_pc_d     = inst_pc_q;
    consume_err_d = consume && !flush && !consume_ok_c;

    if (flush) begin
      state_d      = ST_RUN;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      fetch_addr_d = flush_pc;
      inst_pc_d    = flush_pc;
    end else begin
      case (state_q)
        ST_VEC_LO: begin
          if (mem_ack) begin
            vec_lo_d = mem_rdata;
            state_d  = ST_VEC_HI;
          end
        end
        ST_VEC_HI: begin
          if (mem_ack) begin
            fetch_addr_d = ADDR_W'({mem_rdata, vec_lo_q});
            inst_pc_d    = ADDR_W'({mem_rdata, vec_lo_q});
            state_d      = ST_RUN;
          end
        end
        default: ;
      endcase

      if (push_c) begin
        tail_d       = tail_q + PTR_W'(1);
        fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      end
      if (consume_ok_c) begin
        head_d    = head_q + PTR_W'(consume_len);
        inst_pc_d = inst_pc_q + ADDR_W'(consume_len);
      end
      count_d = count_q + CNT_W'(push_c)
              - (consume_ok_c ? CNT_W'(consume_len) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_VEC_LO;
      vec_lo_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_addr_q  <= '0;
      inst_pc_q     <= '0;
      consume_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_lo_q      <= vec_lo_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      inst_pc_q     <= inst_pc_d;
      consume_err_q <= consume_err_d;
    end
  end

  // Byte storage; only RUN-state transfers are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        queue_q[i] <= '0;
      end
    end else if (push_c) begin
      queue_q[tail_q] <= mem_rdata;
    end
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Byte-wide instruction prefetch unit that sits between the memory bus and prime_decoder.
- After reset it loads the reset vector from 0xFFFC/0xFFFD, then streams opcode bytes from the program counter into a circular byte queue.
- It presents the head opcode plus the next two operand bytes to the decoder.
- On decoder accept it retires 1–3 bytes, per the decoder's instruction length. A branch/jump flush discards the queue and restarts fetching at a new PC.

Parameters:
- DEPTH, 16, queue entries in bytes; power of two, >= 4.
- ADDR_W, 16, memory address width.
- RST_VEC, 16'hFFFC, address of the reset-vector low byte; the high byte is at RST_VEC+1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  read request to the memory bus.
- mem_addr  output  ADDR_W  read address; valid while mem_req=1.
- mem_ack  input  1  read completes this cycle when mem_req & mem_ack.
- mem_rdata  input  8  read data; valid with mem_ack.
- flush  input  1  discard the queue and restart fetching at flush_pc.
- flush_pc  input  ADDR_W  new fetch/instruction address.
- inst_valid  output  1  at least one byte is queued; the opcode is valid.
- inst_op  output  8  queue[head].
- inst_op1  output  8  queue[head+1]; meaningful only when avail >= 2.
- inst_op2  output  8  queue[head+2]; meaningful only when avail >= 3.
- avail  output  2  min(count,3).
- inst_pc  output  ADDR_W  address of inst_op.
- consume  input  1  decoder retires consume_len bytes this cycle.
- consume_len  input  2  bytes to retire, 1..3.
- consume_err  output  1  one-cycle pulse on an illegal consume.

Behaviour:
- Reset (rst_n low, async):
  - State goes to VEC_LO; head, tail and count are 0; fetch_addr and inst_pc are 0.
  - mem_req, inst_valid, avail and consume_err are 0; mem_addr = RST_VEC.
- State machine (VEC_LO, VEC_HI, RUN):
  - VEC_LO: mem_req=1, mem_addr=RST_VEC. On ack, latch vec_lo and go to VEC_HI.
  - VEC_HI: mem_req=1, mem_addr=RST_VEC+1. On ack, set fetch_addr and inst_pc to {rdata,vec_lo} and go to RUN.
  - Vector bytes never enter the queue.
  - RUN: mem_req = (count < DEPTH) & ~flush, and mem_addr = fetch_addr. On each transfer, write rdata to queue[tail], then tail+1 and fetch_addr+1.
  - fetch_addr wraps from 0xFFFF to 0x0000.
- Handshake:
  - mem_addr is stable while mem_req=1 and no ack has occurred.
  - Latency is one cycle from request to ack minimum; the bus may stall arbitrarily.
  - A byte pushed in cycle N appears on the outputs in cycle N+1; there is no bypass.
- Consume:
  - Legal when consume=1, 1 <= consume_len <= avail, and flush=0.
  - A legal consume does head += consume_len, count -= consume_len, and inst_pc += consume_len (mod 2^ADDR_W).
  - consume_len=0 or consume_len > avail: no state change; consume_err=1 in the next cycle only.
  - In VEC states every consume is illegal, because avail=0.
- Simultaneous push and consume: count_next = count + 1 - consume_len. There is no push while full, even if a consume occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Flush (highest priority; any state):
  - Next cycle: head=tail=count=0, fetch_addr=inst_pc=flush_pc, state=RUN.
  - An ack in the flush cycle is discarded; mem_req is 0 in the flush cycle.
  - A consume in the flush cycle is ignored with no consume_err.
  - Flush during VEC_LO/VEC_HI aborts the vector load.
  - Back-to-back flushes: the last flush_pc wins.
  - The first request at flush_pc is issued the cycle after flush.
- Combinational output decode: inst_valid = count != 0; inst_op/op1/op2 are read from head, head+1, head+2 mod DEPTH.

Test Plan:
- Reset vector: the bus returns 0x00 at FFFC and 0x80 at FFFD. Required: the next request is at 0x8000, inst_pc=0x8000, and no vector bytes appear in the queue.
- Fill: hold mem_ack=1 with no consume, streaming bytes 0x01.. from 0x8000. Required: count reaches 16 after 16 transfers, mem_req drops, and inst_op=0x01, op1=0x02, op2=0x03, avail=3.
- Mixed consume: consume lengths 1, 2, 3 from full. Required: inst_op reads 0x02, then 0x04, then 0x07; inst_pc reads 0x8001, then 0x8003, then 0x8006; mem_req reasserts, requesting 0x8010.
- Simultaneous push and consume: count=5, with an ack and consume_len=2 in the same cycle. Required: count becomes 4 and the head advances by 2.
- Illegal consume: with avail=1, drive consume_len=3 (and separately consume_len=0). Required: consume_err pulses for 1 cycle and count, head and inst_pc are unchanged.
- Flush with ack: flush=1, flush_pc=0xFFFE and mem_ack=1 in the same cycle. Required: the acked byte is dropped, count=0, and the next requests are 0xFFFE, 0xFFFF, 0x0000. Consuming 3 bytes then gives inst_pc=0x0001.
